// File: rtl/booth_divider.sv
// Sequential signed divider: restoring division on magnitudes with sign fix-up,
// 2N-bit dividend by N-bit divisor, start/busy/done handshake.
module booth_divider #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           overflow,
  output logic           div_by_zero
);

  localparam int CW = $clog2(2*N) + 1;
  // Smallest quotient magnitude that no longer fits as a positive N-bit value.
  localparam logic [2*N-1:0] Q_LIM = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t         state_q;
  logic [2*N-1:0] rq_q;
  logic [N-1:0]   dvs_q;
  logic [N:0]     part_q;
  logic [CW-1:0]  cnt_q;
  logic           q_neg_q;
  logic           r_neg_q;
  logic           dz_pend_q;
  logic [N-1:0]   quot_q;
  logic [N-1:0]   rem_q;
  logic           busy_q;
  logic           done_q;
  logic           ovf_q;
  logic           dz_q;

  logic [2*N-1:0] dvd_abs;
  logic [N-1:0]   dvs_abs;
  logic [N:0]     shift_val;
  logic           sub_ok;
  logic [N:0]     part_d;
  logic [2*N-1:0] rq_d;
  logic [2*N-1:0] qmag_neg;
  logic [N-1:0]   quot_d;
  logic [N-1:0]   rem_d;
  logic           ovf_d;

  // NOTE: every signal here is assigned on every path, so no latch is inferred.
  always_comb begin
    dvd_abs   = dividend[2*N-1] ? (~dividend + (2*N)'(1)) : dividend;
    dvs_abs   = divisor[N-1] ? (~divisor + N'(1)) : divisor;
    // The dividend register doubles as the quotient register: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    shift_val = {part_q[N-1:0], rq_q[2*N-1]};
    sub_ok    = shift_val >= {1'b0, dvs_q};
    part_d    = sub_ok ? (shift_val - {1'b0, dvs_q}) : shift_val;
    rq_d      = {rq_q[2*N-2:0], sub_ok};
    qmag_neg  = ~rq_q + (2*N)'(1);
    quot_d    = q_neg_q ? qmag_neg[N-1:0] : rq_q[N-1:0];
    rem_d     = r_neg_q ? (~part_q[N-1:0] + N'(1)) : part_q[N-1:0];
    ovf_d     = q_neg_q ? (rq_q > Q_LIM) : (rq_q >= Q_LIM);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rq_q      <= '0;
      dvs_q     <= '0;
      part_q    <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dz_pend_q <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              dz_pend_q <= 1'b1;
              state_q   <= FIN;
            end else begin
              rq_q      <= dvd_abs;
              dvs_q     <= dvs_abs;
              q_neg_q   <= dividend[2*N-1] ^ divisor[N-1];
              r_neg_q   <= dividend[2*N-1];
              part_q    <= '0;
              cnt_q     <= '0;
              dz_pend_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          if (cnt_q == CW'(2*N)) begin
            state_q <= FIN;
          end else begin
            part_q <= part_d;
            rq_q   <= rq_d;
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        FIN: begin
          // First FIN cycle publishes the result; the second ends the pulse.
          if (!done_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            if (dz_pend_q) begin
              quot_q <= '0;
              rem_q  <= '0;
              ovf_q  <= 1'b0;
              dz_q   <= 1'b1;
            end else begin
              quot_q <= quot_d;
              rem_q  <= rem_d;
              ovf_q  <= ovf_d;
              dz_q   <= 1'b0;
            end
          end else begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider (N=4): directed corner cases plus every
// nonzero operand pair in shuffled order against a truncating arithmetic model.
module tb_booth_divider;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           overflow;
  logic           div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  booth_divider #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Truncating signed division straight from integer arithmetic.
  task automatic ref_div(input int a, input int b, output int q4, output int r4, output bit ovf);
    int q;
    int r;
    q   = a / b;
    r   = a % b;
    ovf = (q > 7) || (q < -8);
    q4  = q & 15;
    r4  = r & 15;
  endtask

  // Issue one operation; report latency from the accepting edge and how many
  // samples (after the accepting edge, up to and including done) had busy high.
  task automatic run_op(input int a, input int b, output int lat, output int busy_cnt);
    @(negedge clk);
    start    = 1'b1;
    dividend = a[2*N-1:0];
    divisor  = b[N-1:0];
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = (2*N)'($urandom);
    divisor  = N'($urandom);
    busy_cnt = busy ? 1 : 0;
    lat      = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic expect_op(input string tag, input int a, input int b, input int eq,
                           input int er, input bit eovf, input bit edz);
    int lat;
    int busy_cnt;
    run_op(a, b, lat, busy_cnt);
    check({tag, " quotient"}, 32'(quotient), 32'(eq));
    check({tag, " remainder"}, 32'(remainder), 32'(er));
    check({tag, " overflow"}, 32'(overflow), 32'(eovf));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
    check({tag, " latency"}, 32'(lat), edz ? 32'd1 : 32'd10);
    check({tag, " busy cycles"}, 32'(busy_cnt), edz ? 32'd0 : 32'd10);
  endtask

  int pa[3840];
  int pb[3840];

  initial begin
    int n;
    int hs_lat;
    int done_cnt;
    int eq;
    int er;
    bit eovf;

    #1;
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    expect_op("21/3", 21, 3, 7, 0, 1'b0, 1'b0);
    expect_op("-21/3", -21, 3, 'h9, 0, 1'b0, 1'b0);
    expect_op("22/-3", 22, -3, 'h9, 1, 1'b0, 1'b0);
    expect_op("-22/-3", -22, -3, 7, 'hF, 1'b0, 1'b0);

    expect_op("-16/2", -16, 2, 'h8, 0, 1'b0, 1'b0);
    expect_op("14/2", 14, 2, 7, 0, 1'b0, 1'b0);
    expect_op("16/2", 16, 2, 'h8, 0, 1'b1, 1'b0);
    expect_op("-128/-1", -128, -1, 0, 0, 1'b1, 1'b0);
    expect_op("127/-8", 127, -8, 1, 7, 1'b1, 1'b0);

    expect_op("21/0", 21, 0, 0, 0, 1'b0, 1'b1);
    expect_op("21/7", 21, 7, 3, 0, 1'b0, 1'b0);

    // Starts during CALC, the FIN cycle and the done cycle must all be ignored.
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd21;
    divisor  = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    hs_lat = -1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (done && hs_lat < 0) begin
        hs_lat = k;
        check("handshake quotient", 32'(quotient), 32'd7);
        check("handshake remainder", 32'(remainder), 32'd0);
      end
      start = (k == 3) || (k == 9) || (k == 10);
      if (k == 3) begin dividend = 8'd100; divisor = 4'd7; end
      if (k == 9) begin dividend = 8'hCE;  divisor = 4'd3; end
      if (k == 10) begin dividend = 8'd90; divisor = 4'd5; end
    end
    start = 1'b0;
    check("handshake latency", 32'(hs_lat), 32'd10);
    check("handshake start in done cycle ignored", 32'(busy), 32'd0);
    expect_op("back-to-back 35/5", 35, 5, 7, 0, 1'b0, 1'b0);

    // Reset in the middle of CALC drops the operation without a done pulse.
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd21;
    divisor  = 4'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid-op reset quotient", 32'(quotient), 32'd0);
    check("mid-op reset remainder", 32'(remainder), 32'd0);
    check("mid-op reset busy", 32'(busy), 32'd0);
    check("mid-op reset done", 32'(done), 32'd0);
    check("mid-op reset overflow", 32'(overflow), 32'd0);
    check("mid-op reset div_by_zero", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("mid-op reset no done", 32'(done_cnt), 32'd0);
    expect_op("after reset 35/5", 35, 5, 7, 0, 1'b0, 1'b0);

    // Every nonzero operand pair, in shuffled order.
    n = 0;
    for (int a = -128; a <= 127; a++) begin
      for (int b = -8; b <= 7; b++) begin
        if (b != 0) begin
          pa[n] = a;
          pb[n] = b;
          n++;
        end
      end
    end
    for (int i = n - 1; i > 0; i--) begin
      int j;
      int t;
      j     = $urandom_range(i, 0);
      t     = pa[i]; pa[i] = pa[j]; pa[j] = t;
      t     = pb[i]; pb[i] = pb[j]; pb[j] = t;
    end
    for (int i = 0; i < n; i++) begin
      ref_div(pa[i], pb[i], eq, er, eovf);
      expect_op($sformatf("rand %0d/%0d", pa[i], pb[i]), pa[i], pb[i], eq, er, eovf, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed divider; the inverse companion of the team's Booth multiplier.
- Takes a 2N-bit two's-complement dividend (product-width, e.g. P) and an N-bit two's-complement divisor.
- Returns an N-bit quotient and an N-bit remainder using an iterative restoring algorithm on magnitudes, with sign correction.
- Sits beside the multiplier in the arithmetic datapath and uses a start/busy/done handshake.

Parameters:
- N, 4, operand width: divisor, quotient and remainder are N bits; dividend is 2N bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- dividend  input  2N  signed dividend, captured on the accepted start
- divisor  input  N  signed divisor, captured on the accepted start
- quotient  output  N  signed quotient, truncated toward zero
- remainder  output  N  signed remainder; sign follows the dividend
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when the results are valid
- overflow  output  1  true quotient does not fit in N signed bits
- div_by_zero  output  1  divisor was 0

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy, done, overflow, div_by_zero = 0; quotient, remainder = 0; iteration counter = 0.
  - Reset takes effect immediately, including mid-operation; the in-flight division is discarded with no done pulse.
- States: IDLE, CALC, FIN.
- IDLE, start=1 and divisor≠0 (edge E0):
  - Register |dividend| (2N-bit unsigned; -2^(2N-1) maps to 2^(2N-1)) and |divisor| (N-bit unsigned).
  - Register sign_q = dividend[2N-1]^divisor[N-1] and sign_r = dividend[2N-1].
  - Clear the (N+1)-bit partial remainder; counter=0; busy=1; go to CALC.
- IDLE, start=1 and divisor=0:
  - Go to FIN directly; div_by_zero=1, overflow=0, quotient=0, remainder=0.
  - done is high in the cycle after E0.
- CALC: one restoring step per clock, 2N steps total.
  - Shift partial remainder left, bringing in the next dividend MSB.
  - If partial ≥ |divisor|: subtract and shift 1 into the quotient register; else shift 0.
  - Leave for FIN after step 2N (edge E2N).
- FIN entry (edge E2N+1):
  - Apply signs: quotient = low N bits of (sign_q ? -Qmag : Qmag); remainder = sign_r ? -Rmag : Rmag.
  - overflow=1 when Qmag > 2^(N-1)-1 with sign_q=0, or Qmag > 2^(N-1) with sign_q=1.
  - div_by_zero=0, done=1, busy=0.
- FIN, one cycle later: done=0; return to IDLE.
- Latency: accepted start at E0 → done high in the cycle after E2N+1, i.e. 2N+2 cycles.
  - Divide-by-zero latency is 1 cycle.
- Handshake and output holding:
  - busy stays high from E0 until done asserts.
  - start is ignored while busy=1 and during the FIN cycle.
  - A start in the first IDLE cycle after FIN is accepted, so back-to-back operations are allowed.
  - quotient, remainder, overflow and div_by_zero hold their values until the next completion or reset.
  - Operands may change freely after acceptance without affecting the in-flight result.
- Overflow: remainder is still exact; quotient carries the low N bits of the signed result.
- Width rules:
  - |remainder| < |divisor| ≤ 2^(N-1), so the signed remainder always fits in N bits.
  - Partial remainder is N+1 bits, so the compare never wraps.
  - Counter width is clog2(2N)+1.

Test Plan:
- All cases N=4; "done" means checked at the done pulse.
- Basic signed quadrants: 21/3 → q=7, r=0. -21/3 → q=4'h9 (-7), r=0. 22/-3 → q=-7, r=1. -22/-3 → q=7, r=4'hF (-1). For each: overflow=0, done exactly 10 cycles after the accepted start, busy high for the intervening cycles.
- Quotient boundaries:
  - -16/2 → q=4'h8 (-8), overflow=0.
  - 14/2 → q=7, overflow=0.
  - 16/2 → overflow=1, q=4'h8 (low bits), r=0.
  - -128/-1 → overflow=1, q=4'h0.
  - 127/-8 → q=4'h1 with overflow=1 (true quotient -15), r=7.
- Divide by zero: 21/0 → done on the next cycle, div_by_zero=1, q=0, r=0, busy never high. A following 21/7 → q=3, div_by_zero=0.
- Handshake: start pulses (with different operands) during CALC and during FIN are ignored, and the original result is delivered. A start in the IDLE cycle right after FIN is accepted, and its result appears 10 cycles later.
- Reset mid-op: assert rst_n=0 at step 4 of CALC → all outputs 0 immediately, no done pulse. After release, 35/5 → q=7, r=0.
- Randomised: all 256×15 nonzero operand pairs are compared against a truncating reference model for quotient, remainder and overflow.
